sm_adder_arb: RTL

Round-robin arbiter and two-stage pipeline that shares one 4-bit sign-magnitude adder among several requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants at most one pair per cycle and registers the operands. It then computes the 5-bit sign-magnitude sum and returns it tagged with the requester ID on a single backpressured result port. It sits between the operand-producing clients and any consumer of signed sums.

---
 rtl/sm_adder_arb.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sm_adder_arb.sv
// Round-robin arbiter feeding a two-stage pipeline around one shared 4-bit
// sign-magnitude adder; results leave tagged with the requester ID.
module sm_adder_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 res_valid,
    output logic [4:0]           res_sum,
    output logic [ID_W-1:0]      res_id,
    input  logic                 res_ready,
    output logic                 busy
);

    logic [ID_W-1:0] ptr_q, ptr_d;

    logic            s1_valid_q;
    logic [3:0]      s1_a_q;
    logic [3:0]      s1_b_q;
    logic [ID_W-1:0] s1_id_q;

    logic            s2_valid_q;
    logic [4:0]      s2_sum_q;
    logic [ID_W-1:0] s2_id_q;

    logic            s2_adv;
    logic            s1_adv;
    logic            s1_acc;
    logic            xfer;
    logic [ID_W-1:0] gnt_id;
    logic [3:0]      gnt_a;
    logic [3:0]      gnt_b;
    logic [4:0]      sum_d;

    assign s2_adv = !s2_valid_q || res_ready;
    assign s1_adv = s1_valid_q && s2_adv;
    assign s1_acc = !s1_valid_q || s2_adv;

    // Scan starts at ptr_q and wraps; only the first valid index is granted.
    always_comb begin
        logic found;
        int unsigned idx;
        req_ready = '0;
        gnt_id    = '0;
        found     = 1'b0;
        idx       = 0;
        if (s1_acc && !rst) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = 32'(ptr_q) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!found && req_valid[idx]) begin
                    found          = 1'b1;
                    req_ready[idx] = 1'b1;
                    gnt_id         = ID_W'(idx);
                end
            end
        end
    end

    always_comb begin
        gnt_a = '0;
        gnt_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                gnt_a = req_a[4*i +: 4];
                gnt_b = req_b[4*i +: 4];
            end
        end
    end

    assign xfer = |(req_valid & req_ready);

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end
    end

    always_comb begin
        logic       sa;
        logic       sb;
        logic [3:0] ma;
        logic [3:0] mb;
        logic [3:0] mag;
        logic       sign;
        sa   = s1_a_q[3];
        sb   = s1_b_q[3];
        ma   = {1'b0, s1_a_q[2:0]};
        mb   = {1'b0, s1_b_q[2:0]};
        mag  = '0;
        sign = 1'b0;
        if (sa == sb) begin
            mag  = ma + mb;
            sign = sa;
        end else if (ma >= mb) begin
            mag  = ma - mb;
            sign = sa;
        end else begin
            mag  = mb - ma;
            sign = sb;
        end
        // Zero magnitude is always reported as positive zero.
        if (mag == 4'd0) begin
            sign = 1'b0;
        end
        sum_d = {sign, mag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_id_q    <= '0;
        end else begin
            ptr_q <= ptr_d;

            if (xfer) begin
                s1_valid_q <= 1'b1;
                s1_a_q     <= gnt_a;
                s1_b_q     <= gnt_b;
                s1_id_q    <= gnt_id;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end

            if (s1_adv) begin
                s2_valid_q <= 1'b1;
                s2_sum_q   <= sum_d;
                s2_id_q    <= s1_id_q;
            end else if (s2_adv) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

    assign res_valid = s2_valid_q;
    assign res_sum   = s2_sum_q;
    assign res_id    = s2_id_q;
    assign busy      = s1_valid_q || s2_valid_q;

endmodule
